// File: rtl/button_enable_debouncer_if.sv
// Push-button side of the debouncer: raw button in, press pulse and debounced level out.
// master drives the raw button and observes the outputs; slave is the debouncer itself.
interface button_enable_debouncer_if;
  logic button_i;
  logic enable_o;
  logic button_level_o;

  modport master (
    output button_i,
    input  enable_o,
    input  button_level_o
  );

  modport slave (
    input  button_i,
    output enable_o,
    output button_level_o
  );
endinterface

// File: rtl/button_enable_debouncer.sv
// Synchronizes and debounces a raw push-button into a one-cycle enable pulse per press plus a clean level.
// Latency SYNC_STAGES+STABLE_CYCLES-1 edges; no backpressure. Auto-repeat: BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN.
module button_enable_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  button_enable_debouncer_if.slave    btn
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  if (SYNC_STAGES < 2)   begin : g_bad_sync   $error("SYNC_STAGES must be >= 2");   end
  if (STABLE_CYCLES < 1) begin : g_bad_stable $error("STABLE_CYCLES must be >= 1"); end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat $error("REPEAT_CYCLES must be >= 1"); end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   cnt_done;
  logic                   enable_q, enable_d;
  logic                   level_q, level_d;

`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0]          rpt_q, rpt_d;
`endif

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], btn.button_i};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  // The WAIT state is entered with cnt=1, so the limit is met one count early.
  assign cnt_done = (cnt_q >= CW'(STABLE_CYCLES - 1));
  assign cnt_inc  = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    level_d  = level_q;
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
    rpt_d    = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          level_d  = 1'b1;
          enable_d = 1'b1;
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
          rpt_d    = '0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end else begin
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
          if (rpt_q >= RW'(REPEAT_CYCLES - 1)) begin
            enable_d = 1'b1;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_chain_q <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      enable_q     <= 1'b0;
      level_q      <= 1'b0;
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
      rpt_q        <= '0;
`endif
    end else begin
      sync_chain_q <= sync_chain_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      enable_q     <= enable_d;
      level_q      <= level_d;
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

  assign btn.enable_o       = enable_q;
  assign btn.button_level_o = level_q;

endmodule

// File: tb/tb_button_enable_debouncer.sv
// Directed and randomized bench for button_enable_debouncer against a run-length reference model.
module tb_button_enable_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int REPEAT = 8;
  localparam int ACCEPT = (STABLE > 1) ? STABLE : 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   pulse_cnt;

  button_enable_debouncer_if bif();

  button_enable_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .btn     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the button sample taken at an edge is seen by the debouncer SYNC edges later;
  // a level is accepted after ACCEPT consecutive samples disagreeing with the current level.
  bit m_hist[$];
  bit m_level;
  bit m_pulse;
  int m_run;
  int m_hold;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_run   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input bit b);
    bit s;
    m_hist.push_back(b);
    s = m_hist.pop_front();
    m_pulse = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == ACCEPT) begin
        m_level = s;
        m_pulse = s;
        m_run   = 0;
        m_hold  = 0;
      end
    end else begin
      if (m_level) begin
        if (m_run > 0) begin
          m_hold = 0;
        end else begin
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
          m_hold++;
          if (m_hold == REPEAT) begin
            m_pulse = 1'b1;
            m_hold  = 0;
          end
`endif
        end
      end
      m_run = 0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) model_reset();
    else     model_step(bif.button_i);
    check_eq("enable_vs_model", int'(bif.enable_o), int'(m_pulse));
    check_eq("level_vs_model", int'(bif.button_level_o), int'(m_level));
    if (bif.enable_o) pulse_cnt++;
  end

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    model_reset();
    rst          = 1'b1;
    bif.button_i = 1'b1;

    // Reset held with the button pressed: outputs stay low.
    #1;
    check_eq("reset_enable", int'(bif.enable_o), 0);
    check_eq("reset_level", int'(bif.button_level_o), 0);
    repeat (6) @(negedge clk);
    check_eq("reset_hold_enable", int'(bif.enable_o), 0);
    check_eq("reset_hold_level", int'(bif.button_level_o), 0);
    bif.button_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean press: pulse exactly after edge E+5.
    bif.button_i = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #2;
      check_eq($sformatf("press_enable_k%0d", k), int'(bif.enable_o), (k == 5) ? 1 : 0);
      if (k >= 4) check_eq($sformatf("press_level_k%0d", k), int'(bif.button_level_o), (k >= 5) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    bif.button_i = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #2;
      check_eq($sformatf("release_enable_k%0d", k), int'(bif.enable_o), 0);
      if (k >= 4) check_eq($sformatf("release_level_k%0d", k), int'(bif.button_level_o), (k >= 5) ? 0 : 1);
    end

    // Glitch rejection: bursts shorter than the stability window.
    @(negedge clk);
    pulse_cnt = 0;
    for (int r = 0; r < 10; r++) begin
      bif.button_i = 1'b1;
      repeat (3) @(negedge clk);
      bif.button_i = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_eq("glitch_pulses", pulse_cnt, 0);
    check_eq("glitch_level", int'(bif.button_level_o), 0);

    // Five clean presses feed a 4-bit downstream counter.
    pulse_cnt = 0;
    for (int p = 0; p < 5; p++) begin
      bif.button_i = 1'b1;
      repeat (20) @(negedge clk);
      bif.button_i = 1'b0;
      repeat (20) @(negedge clk);
    end
    check_eq("counter_value", pulse_cnt % 16, 5);

    // Reset while in PRESS_WAIT with cnt=3, then re-debounce the held button.
    bif.button_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    pulse_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("midreset_enable", int'(bif.enable_o), 0);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #2;
      check_eq($sformatf("redebounce_enable_k%0d", k), int'(bif.enable_o), (k == 5) ? 1 : 0);
    end
    check_eq("redebounce_pulses", pulse_cnt, 1);
    @(negedge clk);
    bif.button_i = 1'b0;
    repeat (12) @(negedge clk);

    // Long hold: auto-repeat pulses only when compiled in.
    pulse_cnt    = 0;
    bif.button_i = 1'b1;
    repeat (6) @(posedge clk);
    repeat (36) @(negedge clk);
    bif.button_i = 1'b0;
    repeat (12) @(negedge clk);
`ifdef BUTTON_ENABLE_DEBOUNCER_AUTOREPEAT_EN
    check_eq("hold_pulses", pulse_cnt, 5);
`else
    check_eq("hold_pulses", pulse_cnt, 1);
`endif

    // Random bouncing with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      bif.button_i = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
    end
    bif.button_i = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
